// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: the byte width and the
// state encoding of the transmit arbiter's issue sequencer.
// No ports.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    // IDLE : arbitrate and accept one byte
    // ISSUE: one-cycle write strobe to the uart engine
    // GUARD: covers the engine's one-cycle delay before it raises busy
    // WAIT : hold off until the engine finishes the byte
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Among the requesters that are both
// valid and allowed by the mask, picks the first one found searching
// upward from the pointer, wrapping modulo N.
// Ports:
//   valid  in  N   request vector
//   ptr    in  PW  highest-priority index this cycle
//   mask   in  N   eligibility mask (all ones when unrestricted)
//   winner out N   one-hot winner, 0 when none
//   index  out PW  binary index of the winner (0 when none)
//   any    out 1   a winner exists
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] index,
    output logic          any
);

    logic [N-1:0] eligible;

    assign eligible = valid & mask;

    // Walk the N positions starting at ptr; the first hit is kept because
    // later hits are ignored once any is set.
    always_comb begin
        logic [PW:0] pos;
        winner = '0;
        index  = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            if (!any && eligible[pos[PW-1:0]]) begin
                any   = 1'b1;
                index = pos[PW-1:0];
            end
        end
        if (any) begin
            winner[index] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter sharing one UART transmitter between N_REQ byte
// streams. A packet lock keeps a multi-byte message contiguous; a lock
// timeout releases an owner that stops presenting bytes.
// Ports:
//   clk        in   1         system clock
//   reset      in   1         synchronous, active-high reset
//   req_valid  in   N_REQ     requester i presents a byte
//   req_data   in   8*N_REQ   byte of requester i at [8i+7:8i]
//   req_last   in   N_REQ     byte ends a packet (releases the lock)
//   req_ready  out  N_REQ     one-hot acceptance pulse
//   tx_data    out  8         byte to uart engine, stable until busy falls
//   tx_wr      out  1         one-cycle write strobe
//   tx_busy    in   1         uart transmitter busy
//   grant      out  N_REQ     one-hot current/last owner, 0 after reset
//   locked     out  1         packet lock active
// ---------------------------------------------------------------------------
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int LOCK_TIMEOUT = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]       tx_data,
    output logic                         tx_wr,
    input  logic                         tx_busy,
    output logic [N_REQ-1:0]             grant,
    output logic                         locked
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(LOCK_TIMEOUT);

    tx_state_t      state;
    tx_state_t      next_state;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  owner_idx;
    logic [PW-1:0]  pick_idx;
    logic [PW-1:0]  pick_next;
    logic [PW-1:0]  owner_next;
    logic [N_REQ-1:0] pick_onehot;
    logic [N_REQ-1:0] elig_mask;
    logic           pick_any;
    logic           accept;
    logic           owner_stalled;
    logic           timeout_hit;
    logic [CW-1:0]  idle_cnt;

    // While locked only the owner may win; grant holds the owner one-hot.
    assign elig_mask = locked ? grant : '1;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .mask   (elig_mask),
        .winner (pick_onehot),
        .index  (pick_idx),
        .any    (pick_any)
    );

    assign accept        = (state == IDLE) && pick_any && !tx_busy && !reset;
    assign owner_stalled = (state == IDLE) && locked && !req_valid[owner_idx];
    // A stalled owner cannot also be accepted, so acceptance always wins
    // over an expiring timeout.
    assign timeout_hit   = owner_stalled && (idle_cnt == CW'(LOCK_TIMEOUT - 1));

    assign pick_next  = (pick_idx  == PW'(N_REQ - 1)) ? '0 : pick_idx  + 1'b1;
    assign owner_next = (owner_idx == PW'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tx_wr      = 1'b0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready  = pick_onehot;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                tx_wr      = 1'b1;
                next_state = GUARD;
            end
            GUARD: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (!tx_busy) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Byte latch, ownership, lock and the round-robin pointer. The pointer
    // only moves when ownership is given up, either by a last byte or by
    // the idle timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data   <= '0;
            grant     <= '0;
            locked    <= 1'b0;
            rr_ptr    <= '0;
            owner_idx <= '0;
            idle_cnt  <= '0;
        end else if (accept) begin
            tx_data   <= req_data[pick_idx*UART_BYTE_W +: UART_BYTE_W];
            grant     <= pick_onehot;
            owner_idx <= pick_idx;
            locked    <= ~req_last[pick_idx];
            idle_cnt  <= '0;
            if (req_last[pick_idx]) begin
                rr_ptr <= pick_next;
            end
        end else if (timeout_hit) begin
            locked   <= 1'b0;
            rr_ptr   <= owner_next;
            idle_cnt <= '0;
        end else if (owner_stalled) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
// Self-checking bench for uart_tx_arb with N_REQ=4, LOCK_TIMEOUT=16.
// Stimulus queues one byte stream per requester and pushes the hand-worked
// wire order into a scoreboard; a monitor pops and checks on every tx_wr.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int LT = 16;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       lock;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [3:0]  grant;
    logic        locked;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_len = 4;
    int   busy_left = 0;
    logic ext_busy = 1'b0;

    exp_t       exp_q[$];
    logic [8:0] req_q[4][$];
    logic [3:0] rdy_s;

    int   last_ready_cyc = 0;
    int   last_wr_cyc = 0;
    int   prev_wr_cyc = 0;
    int   busy_fall_cyc = 0;
    int   ready_cnt = 0;
    logic prev_busy = 1'b0;
    logic [7:0] wr_data = '0;

    uart_tx_arb #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART engine model: busy rises the cycle after tx_wr, lasts busy_len.
    always @(posedge clk) begin
        if (reset) begin
            busy_left <= 0;
        end else if (tx_wr) begin
            busy_left <= busy_len;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end
    end

    assign tx_busy = (busy_left != 0) || ext_busy;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        checks = checks + 1;
        if (actual !== required) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Monitor: scoreboard pops on tx_wr, plus handshake/timing checks.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (req_ready != 4'b0000) begin
                    check_output("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                    last_ready_cyc = cyc;
                    ready_cnt = ready_cnt + 1;
                end
                if (tx_wr) begin
                    check_output("wr_latency", cyc, last_ready_cyc + 1);
                    check_output("wr_busy_low", 32'(tx_busy), 32'd0);
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_byte", 32'(tx_data), 32'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("tx_data", 32'(tx_data), 32'(e.data));
                        check_output("grant", 32'(grant), 32'(4'b0001 << e.idx));
                        check_output("locked", 32'(locked), 32'(e.lock));
                    end
                    prev_wr_cyc = last_wr_cyc;
                    last_wr_cyc = cyc;
                    wr_data = tx_data;
                end
                if (busy_left != 0) begin
                    check_output("data_stable", 32'(tx_data), 32'(wr_data));
                end
                if (!tx_busy && prev_busy) begin
                    busy_fall_cyc = cyc;
                end
            end
            prev_busy = tx_busy;
        end
    end

    // One clock of requester driving: retire accepted bytes, present heads.
    task automatic step();
        @(negedge clk);
        rdy_s = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rdy_s[i] && req_q[i].size() > 0) begin
                void'(req_q[i].pop_front());
            end
            if (req_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = req_q[i][0][7:0];
                req_last[i]        = req_q[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic apply_stimulus(input int idx, input logic [7:0] data, input logic last);
        req_q[idx].push_back({last, data});
    endtask

    task automatic expect_byte(input int idx, input logic [7:0] data, input logic lock);
        exp_t e;
        e.idx  = 2'(idx);
        e.data = data;
        e.lock = lock;
        exp_q.push_back(e);
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            check_output("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic drain();
        repeat (busy_len + 6) step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) req_q[i].delete();
        exp_q.delete();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_tx_wr", 32'(tx_wr), 32'd0);
        check_output("rst_tx_data", 32'(tx_data), 32'd0);
        check_output("rst_grant", 32'(grant), 32'd0);
        check_output("rst_locked", 32'(locked), 32'd0);
    endtask

    initial begin
        int rc;

        // Single requester
        do_reset();
        apply_stimulus(0, 8'h41, 1'b1);
        expect_byte(0, 8'h41, 1'b0);
        run_until_done(50);
        check_output("t1_grant_hold", 32'(grant), 32'h1);
        check_output("t1_locked", 32'(locked), 32'd0);
        drain();

        // Fairness: three rounds from all four requesters
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) apply_stimulus(i, 8'(8'h10 + i), 1'b1);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) expect_byte(i, 8'(8'h10 + i), 1'b0);
        run_until_done(500);
        drain();

        // Packet lock: req1's packet stays contiguous ahead of req2
        do_reset();
        apply_stimulus(1, 8'hA0, 1'b0);
        apply_stimulus(1, 8'hA1, 1'b0);
        apply_stimulus(1, 8'hA2, 1'b1);
        apply_stimulus(2, 8'hB0, 1'b1);
        apply_stimulus(2, 8'hB1, 1'b1);
        expect_byte(1, 8'hA0, 1'b1);
        expect_byte(1, 8'hA1, 1'b1);
        expect_byte(1, 8'hA2, 1'b0);
        expect_byte(2, 8'hB0, 1'b0);
        expect_byte(2, 8'hB1, 1'b0);
        run_until_done(300);
        drain();

        // Timeout: owner goes silent; req3 wins after LT idle cycles.
        // Busy low at cycle w, IDLE from w+1, release on idle cycle LT-1,
        // so req3 is accepted at w + LT + 1.
        do_reset();
        apply_stimulus(0, 8'hC0, 1'b0);
        apply_stimulus(3, 8'hD3, 1'b1);
        expect_byte(0, 8'hC0, 1'b1);
        expect_byte(3, 8'hD3, 1'b0);
        run_until_done(200);
        check_output("timeout_delay", last_ready_cyc - busy_fall_cyc, LT + 1);
        drain();

        // Busy handling: external busy blocks acceptance; long busy spacing
        do_reset();
        busy_len = 100;
        ext_busy = 1'b1;
        apply_stimulus(0, 8'hE0, 1'b1);
        apply_stimulus(0, 8'hE1, 1'b1);
        expect_byte(0, 8'hE0, 1'b0);
        expect_byte(0, 8'hE1, 1'b0);
        rc = ready_cnt;
        repeat (10) step();
        check_output("ext_busy_block", ready_cnt - rc, 0);
        ext_busy = 1'b0;
        run_until_done(400);
        check_output("busy_gap", last_wr_cyc - prev_wr_cyc, busy_len + 3);
        drain();
        busy_len = 4;

        // Reset mid-packet while waiting on the engine
        do_reset();
        busy_len = 20;
        apply_stimulus(1, 8'hF0, 1'b0);
        apply_stimulus(1, 8'hF1, 1'b1);
        expect_byte(1, 8'hF0, 1'b1);
        run_until_done(50);
        repeat (4) step();
        check_output("pre_reset_locked", 32'(locked), 32'd1);
        do_reset();
        busy_len = 4;
        apply_stimulus(3, 8'h63, 1'b1);
        apply_stimulus(1, 8'h61, 1'b1);
        expect_byte(1, 8'h61, 1'b0);
        expect_byte(3, 8'h63, 1'b0);
        run_until_done(100);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Round-robin arbiter that shares one UART transmitter (tx_data / tx_wr / tx_busy port of the uart engine) between N_REQ byte-stream requesters, e.g. the CPU-side wb_uart, a debug monitor and a trace unit. Packet lock keeps one requester's multi-byte message contiguous on the wire. A lock timeout stops a stalled owner from starving the others. Sits between the requesters and the uart core; the uart core itself is unchanged.

Parameters:
N_REQ, 4, number of requesters (2..8)
LOCK_TIMEOUT, 50000, idle clk cycles a locked owner may hold the grant without presenting a byte (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  requester i has a byte on req_data[8i+7:8i]
req_data  in  8*N_REQ  flattened byte per requester
req_last  in  N_REQ  byte is the last of a packet; releases the lock
req_ready  out  N_REQ  byte of requester i accepted this cycle (one-hot pulse)
tx_data  out  8  byte to uart engine, held stable from tx_wr until tx_busy falls
tx_wr  out  1  one-cycle write strobe to uart engine
tx_busy  in  1  uart transmitter busy
grant  out  N_REQ  one-hot current/last owner; 0 when unowned
locked  out  1  packet lock active

Behaviour:
- Reset: req_ready=0, tx_wr=0, tx_data=8'h00, grant=0, locked=0, rr pointer=0, timeout counter=0, state=IDLE. Reset mid-byte aborts silently; the byte in flight in the uart is not tracked.
- States:
  - IDLE: if locked, only the owner is eligible; otherwise winner = first asserted req_valid searching from rr pointer upward, wrapping modulo N_REQ. When a winner exists and tx_busy=0: latch req_data into tx_data, pulse req_ready[winner], set grant, go ISSUE. No eligible valid: stay.
  - ISSUE: tx_wr=1 for exactly one cycle -> GUARD.
  - GUARD: one cycle, masks the uart's one-cycle busy latency -> WAIT.
  - WAIT: stay while tx_busy=1; tx_busy=0 -> IDLE.
- Acceptance latency: byte accepted in cycle t -> tx_wr in t+1. Minimum inter-byte spacing is 3 cycles plus uart busy time.
- Lock: on acceptance, locked <= ~req_last[winner]. A byte with last=1 clears the lock. If not locked after acceptance, rr pointer <= winner+1 (mod N_REQ). While locked, rr pointer is unchanged.
- Timeout: counter counts cycles in IDLE with locked=1 and owner req_valid=0. Reset on any acceptance. Reaching LOCK_TIMEOUT-1: locked<=0, rr pointer<=owner+1, counter<=0. The owner's next byte then arbitrates normally.
- Simultaneous events: owner valid in the same cycle the timeout expires -> acceptance wins, no release. Multiple valids -> exactly one req_ready.
- Requesters must hold req_valid/data/last stable until req_ready. Dropping req_valid early is legal and loses nothing.
- tx_busy=1 in IDLE (external activity) -> no acceptance until it clears.
- grant keeps the last owner between bytes. grant=0 only after reset.

Decomposition:
- Shared package uart_pkg: state encoding (IDLE, ISSUE, GUARD, WAIT), UART_BYTE_W=8.
- Sub-module rr_pick: combinational round-robin picker (inputs valid vector, pointer, lock mask; outputs one-hot winner and index). Reusable by future bus arbiters.

Test Plan:
- Single requester: req0 sends 8'h41 last=1 -> req_ready[0] in cycle 0, tx_wr in cycle 1 with tx_data=8'h41, grant=0001, locked=0.
- Fairness: all 4 send unlimited last=1 bytes 0x10..0x13 -> wire order 0x10,0x11,0x12,0x13,0x10…; each requester gets exactly 1 of every 4 grants.
- Packet lock: req1 sends 0xA0,0xA1,0xA2 (last on 0xA2) while req2 is continuously valid -> all three req1 bytes go out before any req2 byte; locked=1 after 0xA0, 0 after 0xA2.
- Timeout: LOCK_TIMEOUT=16; req0 sends one last=0 byte then drops valid; req3 valid -> lock released on idle cycle 15, req3 byte is the next tx_wr.
- Busy handling: uart model holds tx_busy for 100 cycles -> no second tx_wr until tx_busy=0; tx_data stable throughout.
- Reset mid-packet: reset asserted in WAIT with locked=1 -> next cycle all outputs at reset values. The lowest-index valid requester wins first.
